// File: rtl/ev_ctl_pkg.sv
// Shared definitions for the EV motor-controller command sequencer:
// op codes, response codes, FSM states and feedback pin indices.
package ev_ctl_pkg;

  localparam logic [2:0] OP_POWER     = 3'd0;
  localparam logic [2:0] OP_HEADLIGHT = 3'd1;
  localparam logic [2:0] OP_HORN      = 3'd2;
  localparam logic [2:0] OP_INDICATOR = 3'd3;
  localparam logic [2:0] OP_SPEED     = 3'd4;
  localparam logic [2:0] OP_PWM       = 3'd5;
  localparam logic [2:0] OP_MONITOR   = 3'd6;
  localparam logic [2:0] OP_STATUS    = 3'd7;
  // Parked op code: monitor has no side effects on the controller.
  localparam logic [2:0] OP_IDLE      = 3'b110;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_TIMEOUT = 2'b01;
  localparam logic [1:0] RSP_REJECT  = 2'b10;
  localparam logic [1:0] RSP_FAULT   = 2'b11;

  localparam int FB_PWR  = 0;
  localparam int FB_HL   = 1;
  localparam int FB_HORN = 2;
  localparam int FB_IND  = 3;
  localparam int FB_HOT  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Expected controller speed: accel minus brake, clamped at zero.
  function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : 4'd0;
  endfunction

endpackage

// File: rtl/ev_nib_mux.sv
// Time-multiplexed accel/brake nibble. The phase register mirrors the
// controller's data_select toggle, so both leave reset at 0 together.
module ev_nib_mux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [3:0] accel_i,
  input  logic [3:0] brake_i,
  output logic [3:0] nib_o
);

  logic phase_q;

  // Free-running phase toggle, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= 1'b0;
    else        phase_q <= ~phase_q;
  end

  // Accel on phase 0, brake on phase 1, zero when no speed command is active.
  always_comb begin
    nib_o = 4'd0;
    if (en_i) nib_o = phase_q ? brake_i : accel_i;
  end

endmodule

// File: rtl/ev_cmd_sequencer.sv
// Command-side sequencer: accepts one command, drives the controller pins,
// confirms the effect through the status pins and returns a response code.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | pins parked on monitor op, cmd_ready high
// ST_DRIVE | latched op driven for HOLD_CYCLES cycles before checking
// ST_CHECK | feedback compared every cycle, bounded by TIMEOUT cycles
// ST_RESP  | one-cycle rsp_valid pulse, pins parked again
module ev_cmd_sequencer
  import ev_ctl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_src,
  input  logic       cmd_on,
  input  logic [3:0] cmd_accel,
  input  logic [3:0] cmd_brake,
  output logic [7:0] ctl_ui,
  output logic [3:0] ctl_uio,
  output logic [3:0] ctl_nib,
  input  logic [7:0] fb_uo,
  input  logic [3:0] fb_speed_hi,
  output logic       rsp_valid,
  output logic [1:0] rsp_code,
  output logic       busy
);

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TO_LD   = 8'(TIMEOUT - 1);
  localparam logic [7:0] UI_IDLE = {5'b0, OP_IDLE};

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] op_q;
  logic       on_q;
  logic [3:0] accel_q, brake_q, target_q;
  logic [7:0] ui_q;
  logic [3:0] uio_q;
  logic       nib_en_q;
  logic       rsp_valid_q;
  logic [1:0] rsp_code_q;

  logic [7:0] ui_d;
  logic [3:0] uio_d;
  logic       reject_d, met_d, hot_d;
  logic       unused_fb;

  assign unused_fb = ^{fb_uo[7:6], fb_uo[4]};

  // Pin image for the incoming command: selected line carries cmd_on, partner 0.
  always_comb begin
    ui_d       = 8'd0;
    uio_d      = 4'd0;
    ui_d[2:0]  = cmd_op;
    ui_d[5]    = cmd_src;
    case (cmd_op)
      OP_POWER:     begin ui_d[3]  = cmd_on & ~cmd_src; ui_d[4]  = cmd_on & cmd_src; end
      OP_HEADLIGHT: begin ui_d[6]  = cmd_on & ~cmd_src; ui_d[7]  = cmd_on & cmd_src; end
      OP_HORN:      begin uio_d[0] = cmd_on & ~cmd_src; uio_d[1] = cmd_on & cmd_src; end
      OP_INDICATOR: begin uio_d[2] = cmd_on & ~cmd_src; uio_d[3] = cmd_on & cmd_src; end
      default: ;
    endcase
  end

  // Accessory and speed ops are refused while the controller reports power off.
  assign reject_d = ~fb_uo[FB_PWR] &
                    ((cmd_op == OP_HEADLIGHT) || (cmd_op == OP_HORN) ||
                     (cmd_op == OP_INDICATOR) || (cmd_op == OP_SPEED));

  // Per-op confirmation of the latched command against the status pins.
  always_comb begin
    met_d = 1'b0;
    case (op_q)
      OP_POWER:     met_d = (fb_uo[FB_PWR]  == on_q);
      OP_HEADLIGHT: met_d = (fb_uo[FB_HL]   == on_q);
      OP_HORN:      met_d = (fb_uo[FB_HORN] == on_q);
      OP_INDICATOR: met_d = (fb_uo[FB_IND]  == on_q);
      OP_SPEED:     met_d = (fb_speed_hi == target_q);
      OP_PWM, OP_MONITOR, OP_STATUS: met_d = 1'b1;
    endcase
  end

  assign hot_d = fb_uo[FB_HOT] & ((op_q == OP_SPEED) || (op_q == OP_PWM));

  // Sequencer FSM with registered pin drive and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      op_q        <= OP_IDLE;
      on_q        <= 1'b0;
      accel_q     <= 4'd0;
      brake_q     <= 4'd0;
      target_q    <= 4'd0;
      ui_q        <= UI_IDLE;
      uio_q       <= 4'd0;
      nib_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RSP_OK;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            on_q     <= cmd_on;
            accel_q  <= cmd_accel;
            brake_q  <= cmd_brake;
            target_q <= sat_sub4(cmd_accel, cmd_brake);
            if (reject_d) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_code_q  <= RSP_REJECT;
            end else begin
              state_q  <= ST_DRIVE;
              cnt_q    <= HOLD_LD;
              ui_q     <= ui_d;
              uio_q    <= uio_d;
              nib_en_q <= (cmd_op == OP_SPEED);
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_CHECK;
            cnt_q   <= TO_LD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_CHECK: begin
          if (hot_d || met_d || (cnt_q == 8'd0)) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= hot_d ? RSP_FAULT : (met_d ? RSP_OK : RSP_TIMEOUT);
            ui_q        <= UI_IDLE;
            uio_q       <= 4'd0;
            nib_en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ev_nib_mux u_nib (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (nib_en_q),
    .accel_i(accel_q),
    .brake_i(brake_q),
    .nib_o  (ctl_nib)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ctl_ui    = ui_q;
  assign ctl_uio   = uio_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;

endmodule

// File: tb/tb_ev_cmd_sequencer.sv
// Bench for ev_cmd_sequencer with a small behavioural motor-controller model.
module tb_ev_cmd_sequencer;
  import ev_ctl_pkg::*;

  localparam int HOLD = 4;
  localparam int TO   = 10;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, cmd_src, cmd_on;
  logic [2:0] cmd_op;
  logic [3:0] cmd_accel, cmd_brake;
  logic [7:0] ctl_ui;
  logic [3:0] ctl_uio, ctl_nib;
  logic [7:0] fb_uo;
  logic [3:0] fb_speed_hi;
  logic       rsp_valid, busy;
  logic [1:0] rsp_code;

  int n_total = 0;
  int n_bad   = 0;

  ev_cmd_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_on(cmd_on), .cmd_accel(cmd_accel), .cmd_brake(cmd_brake),
    .ctl_ui(ctl_ui), .ctl_uio(ctl_uio), .ctl_nib(ctl_nib),
    .fb_uo(fb_uo), .fb_speed_hi(fb_speed_hi),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Motor controller model: XOR of line pairs, accel/brake latched by data_select.
  logic m_pwr, m_hl, m_horn, m_ind, m_phase;
  logic [3:0] m_acc, m_brk;
  logic stuck_horn, force_hot;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pwr <= 0; m_hl <= 0; m_horn <= 0; m_ind <= 0; m_phase <= 0;
      m_acc <= 0; m_brk <= 0;
    end else begin
      m_phase <= ~m_phase;
      case (ctl_ui[2:0])
        3'd0: m_pwr  <= ctl_ui[3] ^ ctl_ui[4];
        3'd1: m_hl   <= ctl_ui[6] ^ ctl_ui[7];
        3'd2: m_horn <= ctl_uio[0] ^ ctl_uio[1];
        3'd3: m_ind  <= ctl_uio[2] ^ ctl_uio[3];
        3'd4: if (m_phase) m_brk <= ctl_nib; else m_acc <= ctl_nib;
        default: ;
      endcase
    end
  end

  assign fb_uo       = {2'b00, force_hot, 1'b0, m_ind, m_horn & ~stuck_horn, m_hl, m_pwr};
  assign fb_speed_hi = (m_acc > m_brk) ? (m_acc - m_brk) : 4'd0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] exp_ui(input logic [2:0] op, input logic src, input logic on);
    logic [7:0] u;
    u = 8'h00;
    u[2:0] = op;
    u[5] = src;
    if (op == 3'd0) u[src ? 4 : 3] = on;
    if (op == 3'd1) u[src ? 7 : 6] = on;
    return u;
  endfunction

  function automatic logic [3:0] exp_uio(input logic [2:0] op, input logic src, input logic on);
    logic [3:0] u;
    u = 4'h0;
    if (op == 3'd2) u[src ? 1 : 0] = on;
    if (op == 3'd3) u[src ? 3 : 2] = on;
    return u;
  endfunction

  // Reference response from the command rules and the tracked power state.
  logic       pwr_ref;
  logic [1:0] last_code;

  function automatic logic [1:0] ref_code(input logic [2:0] op, input logic on,
                                          input logic stuck, input logic hot);
    if (op >= 3'd1 && op <= 3'd4 && !pwr_ref) return RSP_REJECT;
    if ((op == 3'd4 || op == 3'd5) && hot)    return RSP_FAULT;
    if (op == 3'd2 && stuck && on)            return RSP_TIMEOUT;
    return RSP_OK;
  endfunction

  // Issue one command and check pins, pulse timing and code every cycle.
  task automatic run_cmd(input string nm, input logic [2:0] op, input logic src, input logic on,
                         input logic [3:0] a, input logic [3:0] b, input logic stuck,
                         input logic hot, input logic [1:0] code);
    int lat;
    bit act;
    int spd;
    lat = (code == RSP_REJECT) ? 1 : (code == RSP_TIMEOUT) ? HOLD + 1 + TO : HOLD + 2;
    cmd_valid = 1; cmd_op = op; cmd_src = src; cmd_on = on; cmd_accel = a; cmd_brake = b;
    stuck_horn = stuck; force_hot = hot;
    @(negedge clk);
    chk({nm, ".ready"}, cmd_ready, 1);
    chk({nm, ".code_hold"}, rsp_code, last_code);
    chk({nm, ".idle_ui"}, ctl_ui, 8'h06);
    @(posedge clk); #1;
    cmd_valid = 0;
    cmd_op = 3'($urandom); cmd_src = 1'($urandom); cmd_on = 1'($urandom);
    cmd_accel = 4'($urandom); cmd_brake = 4'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      act = (code != RSP_REJECT) && (k < lat);
      chk({nm, ".ui"},  ctl_ui,  act ? exp_ui(op, src, on)  : 8'h06);
      chk({nm, ".uio"}, ctl_uio, act ? exp_uio(op, src, on) : 4'h0);
      chk({nm, ".nib"}, ctl_nib, (act && op == 3'd4) ? (m_phase ? b : a) : 4'h0);
      chk({nm, ".rsp_valid"}, rsp_valid, (k == lat));
      chk({nm, ".busy"}, busy, 1);
      if (k == lat) begin
        chk({nm, ".rsp_code"}, rsp_code, code);
        chk({nm, ".ready_resp"}, cmd_ready, 0);
        if (op == 3'd4 && code == RSP_OK) begin
          spd = (int'(a) > int'(b)) ? int'(a) - int'(b) : 0;
          chk({nm, ".speed"}, fb_speed_hi, spd);
        end
      end
      @(posedge clk); #1;
    end
    last_code = code;
    stuck_horn = 0; force_hot = 0;
    if (op == 3'd0) pwr_ref = on;
  endtask

  typedef struct {
    logic [2:0] op;
    logic       src, on;
    logic [3:0] a, b;
    logic       stuck, hot;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, RSP_OK};      // power on, PLC
    tbl[1]  = '{3'd4, 1'b0, 1'b0, 4'd9, 4'd3, 1'b0, 1'b0, RSP_OK};      // speed 6
    tbl[2]  = '{3'd4, 1'b1, 1'b0, 4'd2, 4'd7, 1'b0, 1'b0, RSP_OK};      // speed clamps to 0
    tbl[3]  = '{3'd1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, RSP_OK};      // headlight via HMI
    tbl[4]  = '{3'd2, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, RSP_TIMEOUT}; // horn stuck
    tbl[5]  = '{3'd4, 1'b0, 1'b0, 4'd5, 4'd1, 1'b0, 1'b1, RSP_FAULT};   // overheat on speed
    tbl[6]  = '{3'd5, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, RSP_FAULT};   // overheat on PWM load
    tbl[7]  = '{3'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, RSP_OK};      // status ignores heat
    tbl[8]  = '{3'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, RSP_OK};      // power off, HMI
    tbl[9]  = '{3'd1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, RSP_REJECT};
    tbl[10] = '{3'd4, 1'b0, 1'b0, 4'd8, 4'd1, 1'b0, 1'b1, RSP_REJECT};
    tbl[11] = '{3'd6, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, RSP_OK};
    tbl[12] = '{3'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, RSP_REJECT};

    cmd_valid = 0; cmd_op = 0; cmd_src = 0; cmd_on = 0; cmd_accel = 0; cmd_brake = 0;
    stuck_horn = 0; force_hot = 0; pwr_ref = 0; last_code = RSP_OK;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_code", rsp_code, 2'b00);
    chk("rst.ui", ctl_ui, 8'h06);
    chk("rst.uio", ctl_uio, 4'h0);
    chk("rst.nib", ctl_nib, 4'h0);
    @(posedge clk); #1;
    rst_n = 1;

    for (int i = 0; i < 13; i++)
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].src, tbl[i].on, tbl[i].a, tbl[i].b,
              tbl[i].stuck, tbl[i].hot, tbl[i].code);

    // Reset in the middle of CHECK: no response, next command accepted normally.
    run_cmd("pre_rst", 3'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, RSP_OK);
    cmd_valid = 1; cmd_op = 3'd2; cmd_src = 0; cmd_on = 1; stuck_horn = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (HOLD + 2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst.busy_before", busy, 1);
    chk("midrst.ui_before", ctl_ui[2:0], 3'd2);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; stuck_horn = 0; pwr_ref = 0; last_code = RSP_OK;
    @(negedge clk);
    chk("midrst.busy", busy, 0);
    chk("midrst.ui", ctl_ui, 8'h06);
    chk("midrst.uio", ctl_uio, 4'h0);
    chk("midrst.ready", cmd_ready, 1);
    for (int k = 0; k < 2 * TO; k++) begin
      chk("midrst.no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    run_cmd("post_rst0", 3'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, RSP_OK);
    run_cmd("post_rst1", 3'd1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, RSP_OK);

    // Randomized commands against the reference rules.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic src, on, stuck, hot;
      logic [3:0] a, b;
      op    = 3'($urandom_range(0, 7));
      src   = 1'($urandom_range(0, 1));
      on    = 1'($urandom_range(0, 1));
      if (op == 3'd0) on = ($urandom_range(0, 3) != 0);
      a     = 4'($urandom_range(0, 15));
      b     = 4'($urandom_range(0, 15));
      stuck = (op == 3'd2) && ($urandom_range(0, 2) == 0);
      hot   = ($urandom_range(0, 3) == 0);
      run_cmd($sformatf("rnd%0d", i), op, src, on, a, b, stuck, hot,
              ref_code(op, on, stuck, hot));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ev_cmd_sequencer.md
# ev_cmd_sequencer

Command-side sequencer for the EV motor controller. It accepts one high-level command at a time over a valid/ready handshake and drives the controller's pins with the PLC/HMI lines, operation code and time-multiplexed accelerator/brake nibble. It then reads the controller's status pins back to confirm the command took effect and returns a response code. It sits between the PLC/HMI front end and the motor controller, on the same clock and reset.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles an operation is driven before checking starts; legal range 3..15.
- `TIMEOUT`, default 64: maximum number of CHECK cycles before a timeout response; legal range 1..255.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low. It is the same net as the controller's reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high in IDLE only.
- `cmd_op` in 3: operation code. 0 power, 1 headlight, 2 horn, 3 right indicator, 4 speed, 5 PWM load, 6 monitor, 7 status.
- `cmd_src` in 1: source line to drive. 0 = PLC line, 1 = HMI line.
- `cmd_on` in 1: requested state for ops 0..3.
- `cmd_accel` in 4, `cmd_brake` in 4: operands for op 4.
- `ctl_ui` out 8: drives the controller's `ui_in`.
- `ctl_uio` out 4: drives the controller's `uio_in[3:0]`.
- `ctl_nib` out 4: drives the controller's `uio_in[7:4]`.
- `fb_uo` in 8: the controller's `uo_out`.
- `fb_speed_hi` in 4: the controller's `uio_out[7:4]`.
- `rsp_valid` out 1: one-cycle pulse.
- `rsp_code` out 2: 00 OK, 01 TIMEOUT, 10 REJECT, 11 FAULT.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, DRIVE, CHECK and RESP. Transitions:
  - IDLE → DRIVE on `cmd_valid & cmd_ready`.
  - DRIVE → CHECK after `HOLD_CYCLES`.
  - CHECK → RESP when the check is met or the timeout counter expires.
  - RESP → IDLE after one cycle.
- Command fields are latched on handshake. Input changes after acceptance are ignored.
- Pin drive outside DRIVE/CHECK:
  - `ctl_ui[2:0]` = 3'b110, the monitor op, which has no side effects.
  - All other `ctl_ui` and `ctl_uio` bits are 0.
- Pin drive during DRIVE/CHECK:
  - `ctl_ui[2:0]` = the latched op.
  - The selected source line carries `cmd_on`; its partner line carries 0, so the controller's XOR equals `cmd_on`.
  - Line pairs: op 0 → ui[3]/ui[4]; op 1 → ui[6]/ui[7]; op 2 → uio[0]/uio[1]; op 3 → uio[2]/uio[3]. `ui[5]` = `cmd_src`.
- Nibble mux:
  - A `phase` register resets to 0 and toggles every cycle, tracking the controller's data_select.
  - `ctl_nib` is combinational: `phase`=0 gives the latched accel, `phase`=1 gives the latched brake.
  - Outside an op-4 command, `ctl_nib` = 0.
- Immediate REJECT (IDLE → RESP, nothing driven) for op 1..4 when `fb_uo[0]`=0 at acceptance (power off).
- Check condition per op:
  - op 0: `fb_uo[0]` = `cmd_on`.
  - op 1: `fb_uo[1]` = `cmd_on`.
  - op 2: `fb_uo[2]` = `cmd_on`.
  - op 3: `fb_uo[3]` = `cmd_on`.
  - op 4: `fb_speed_hi` = (accel > brake ? accel − brake : 0), computed as 4-bit unsigned with no wrap.
  - ops 5..7: always met; they respond OK on the first CHECK cycle.
- FAULT: if `fb_uo[5]` (overheat) is 1 during CHECK of op 4 or 5, respond FAULT immediately.

## Timing
- Reset values:
  - State IDLE; `cmd_ready`=1; `busy`=0; `rsp_valid`=0; `rsp_code`=00.
  - `ctl_ui`=8'b0000_0110; `ctl_uio`=0; `ctl_nib`=0; `phase`=0.
- Handshake to first driven op: 1 cycle.
- Minimum handshake-to-`rsp_valid` latency: `HOLD_CYCLES`+2 cycles.
- REJECT latency: `rsp_valid` 1 cycle after handshake.
- CHECK samples feedback every cycle.
- TIMEOUT: after `TIMEOUT` CHECK cycles without the check met, respond TIMEOUT.
- `rsp_code` is valid only while `rsp_valid` is high. It holds its last value otherwise.
- `cmd_ready` is low in RESP. A new command can be accepted the cycle after RESP.
- Reset mid-command: the state returns to IDLE on the next edge, and no response is issued for the aborted command.

## Structure
- Package `ev_ctl_pkg` holds:
  - op code localparams (OP_POWER..OP_STATUS, OP_IDLE = 3'b110);
  - response codes;
  - the state enum;
  - feedback bit indices (FB_PWR=0, FB_HL=1, FB_HORN=2, FB_IND=3, FB_HOT=5).
- One sub-module, `ev_nib_mux`: the phase toggle register plus the accel/brake select.

## Test plan
- Power-on: op 0, src PLC, on=1, with the controller model → PLC line high and HMI line 0; `fb_uo[0]` rises; response OK at cycle `HOLD_CYCLES`+2.
- Speed: power on, op 4, accel=9, brake=3 → `ctl_nib` alternates 9/3 in phase with the controller; `fb_speed_hi`=6; response OK. Repeat with accel=2, brake=7 → expected value 0; response OK.
- Reject: power off, op 1 on=1 → response REJECT 1 cycle after handshake; the headlight lines are never driven.
- Timeout: op 2 with the model's horn output stuck at 0 → TIMEOUT exactly `TIMEOUT` cycles after CHECK entry; `ctl_ui[2:0]` returns to 110.
- Fault: overheat bit forced to 1 during op 4 CHECK → response FAULT on that cycle.
- Reset mid-CHECK → IDLE, `ctl_ui`=0x06, no `rsp_valid`; the next command is accepted normally.
